// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: bundles the copy engine's job-control and RAM-port signals.
//   Job control : start, mode, abort, src_addr, dst_addr, len, fill_val (to engine)
//                 busy, done (from engine)
//   RAM port    : mem_addr, mem_data, mem_we (from engine), mem_q (to engine)
//   master : host / RAM side that drives job requests and read data
//   slave  : the engine itself
interface mem_copy_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              mode;
  logic              abort;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, abort, src_addr, dst_addr, len, fill_val, mem_q,
    input  mem_addr, mem_data, mem_we, busy, done
  );

  modport slave (
    input  start, mode, abort, src_addr, dst_addr, len, fill_val, mem_q,
    output mem_addr, mem_data, mem_we, busy, done
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: drives one port of a synchronous RAM (registered read data,
// one cycle latency) to perform memmove-style block copy or block fill.
//   clk  : single clock, posedge
//   rst  : synchronous active-high reset
//   bus  : mem_copy_engine_if.slave -- job request (start/mode/abort/src/dst/len/
//          fill_val), status (busy/done pulse) and RAM port (mem_addr/mem_data/
//          mem_we out, mem_q in)
// RAM port outputs are decoded from registered state only; mem_q passes straight
// through to mem_data during a copy write.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  mem_copy_engine_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              mode_q, mode_d;
  logic              desc_q, desc_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] step_c;

  // Pointer increment: all-ones is -1 modulo 2^ADDR_W, so both directions wrap silently.
  assign step_c = desc_q ? {ADDR_W{1'b1}} : ADDR_W'(1);

  // State and job registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      desc_q  <= 1'b0;
      fill_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      desc_q  <= desc_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  // Next-state and job bookkeeping.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    desc_d  = desc_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d = bus.mode;
            fill_d = bus.fill_val;
            rem_d  = bus.len;
            // Copy runs top-down when the destination sits above the source so
            // overlapping source bytes are read before being overwritten.
            desc_d = ~bus.mode & (bus.dst_addr > bus.src_addr);
            if (desc_d) begin
              src_d = bus.src_addr + bus.len - ADDR_W'(1);
              dst_d = bus.dst_addr + bus.len - ADDR_W'(1);
            end else begin
              src_d = bus.src_addr;
              dst_d = bus.dst_addr;
            end
            state_d = bus.mode ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = bus.abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        src_d = src_q + step_c;
        dst_d = dst_q + step_c;
        rem_d = rem_q - ADDR_W'(1);
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == ADDR_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = mode_q ? ST_WR : ST_RD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port decode; everything is zero outside RD/WR.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_we   = 1'b0;
    case (state_q)
      ST_RD: begin
        bus.mem_addr = src_q;
      end
      ST_WR: begin
        bus.mem_addr = dst_q;
        bus.mem_we   = 1'b1;
        bus.mem_data = mode_q ? fill_q : bus.mem_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;

endmodule
